// File: rtl/rgb_pwm_meter.sv
// rtl/rgb_pwm_meter.sv - three-channel PWM period/high-time capture with stall detection
//
// Purpose: samples three asynchronous PWM inputs (red, green, blue), measures each
// channel's period and high time in clk100mhz cycles, and flags channels that stop
// producing rising edges for TIMEOUT cycles.
//
// Ports:
//   clk100mhz  in   system clock, all logic on rising edge
//   rst_n      in   asynchronous active-low reset
//   pwm_i      in   [2:0] PWM inputs (0 = red, 1 = green, 2 = blue), asynchronous
//   period_o   out  [3*CNT_W-1:0] last period per channel, channel k at [k*CNT_W +: CNT_W]
//   high_o     out  [3*CNT_W-1:0] last high time per channel, same packing
//   valid_o    out  [2:0] one-cycle update strobe per channel
//   static_o   out  [2:0] channel timed out
//   level_o    out  [2:0] synchronized level captured at timeout
module rgb_pwm_meter #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic                 clk100mhz,
   input  logic                 rst_n,
   input  logic [2:0]           pwm_i,
   output logic [3*CNT_W-1:0]   period_o,
   output logic [3*CNT_W-1:0]   high_o,
   output logic [2:0]           valid_o,
   output logic [2:0]           static_o,
   output logic [2:0]           level_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   typedef enum logic {IDLE, MEASURE} state_t;

   for (genvar k = 0; k < 3; k++) begin : g_ch
      logic             s1_q, s2_q, s3_q;
      logic             s1_d, s2_d, s3_d;
      state_t           state_q, state_d;
      logic [CNT_W-1:0] period_ctr_q, period_ctr_d;
      logic [CNT_W-1:0] high_ctr_q, high_ctr_d;
      logic [CNT_W-1:0] period_q, period_d;
      logic [CNT_W-1:0] high_q, high_d;
      logic             valid_q, valid_d;
      logic             static_q, static_d;
      logic             level_q, level_d;
      logic             rise;
      logic             timeout;

      assign s1_d = pwm_i[k];
      assign s2_d = s1_q;
      assign s3_d = s2_q;

      assign rise    = s2_q & ~s3_q;
      // A rise in the same cycle the counter reaches TIMEOUT is a normal measurement.
      assign timeout = (state_q == MEASURE) && !rise && (period_ctr_q == TIMEOUT_C);

      // State register
      always_ff @(posedge clk100mhz or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= IDLE;
         end else begin
            state_q <= state_d;
         end
      end

      // Next-state logic
      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE:    if (rise)    state_d = MEASURE;
            MEASURE: if (timeout) state_d = IDLE;
            default:              state_d = IDLE;
         endcase
      end

      // Output / datapath logic
      always_comb begin
         period_ctr_d = period_ctr_q;
         high_ctr_d   = high_ctr_q;
         period_d     = period_q;
         high_d       = high_q;
         static_d     = static_q;
         level_d      = level_q;
         valid_d      = 1'b0;
         case (state_q)
            IDLE: begin
               period_ctr_d = '0;
               high_ctr_d   = '0;
               // First edge only arms the counters; there is no previous edge to measure from.
               if (rise) begin
                  period_ctr_d = ONE_C;
                  high_ctr_d   = ONE_C;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_d     = period_ctr_q;
                  high_d       = high_ctr_q;
                  static_d     = 1'b0;
                  valid_d      = 1'b1;
                  period_ctr_d = ONE_C;
                  high_ctr_d   = ONE_C;
               end else if (timeout) begin
                  period_d     = '0;
                  high_d       = '0;
                  static_d     = 1'b1;
                  level_d      = s2_q;
                  valid_d      = 1'b1;
                  period_ctr_d = '0;
                  high_ctr_d   = '0;
               end else begin
                  period_ctr_d = period_ctr_q + ONE_C;
                  if (s2_q) high_ctr_d = high_ctr_q + ONE_C;
               end
            end
            default: begin
               period_ctr_d = '0;
               high_ctr_d   = '0;
            end
         endcase
      end

      // Synchronizer, counters and result registers
      always_ff @(posedge clk100mhz or negedge rst_n) begin
         if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            period_ctr_q <= '0;
            high_ctr_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            static_q     <= 1'b0;
            level_q      <= 1'b0;
         end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            period_ctr_q <= period_ctr_d;
            high_ctr_q   <= high_ctr_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            static_q     <= static_d;
            level_q      <= level_d;
         end
      end

      assign period_o[k*CNT_W +: CNT_W] = period_q;
      assign high_o[k*CNT_W +: CNT_W]   = high_q;
      assign valid_o[k]                 = valid_q;
      assign static_o[k]                = static_q;
      assign level_o[k]                 = level_q;
   end

endmodule
